// File: rtl/interrupt_controller_if.sv
// Bundle between the interrupt controller and the core / syscall-table writer.
// Handshake: the controller raises s_interruption for exactly one cycle with
// dir_out/active_id already valid and busy=1; those stay stable until the
// core answers with s_finished=1 for at least one cycle, after which busy
// drops and the next dispatch may start. There is no back-pressure on the
// request side: irq_in edges and i_syscall pulses are always accepted.
interface interrupt_controller_if #(
  parameter int N_SRC    = 4,
  parameter int ADDR_W   = 10,
  parameter int SC_DEPTH = 4,
  parameter int IMM_W    = 8
);
  logic [N_SRC-1:0]              irq_in;
  logic [N_SRC-1:0]              irq_en;
  logic                          i_syscall;
  logic [IMM_W-1:0]              inmediate_syscall;
  logic                          s_finished;
  logic                          tbl_we;
  logic [$clog2(SC_DEPTH)-1:0]   tbl_addr;
  logic [ADDR_W-1:0]             tbl_data;
  logic [ADDR_W-1:0]             dir_out;
  logic                          s_interruption;
  logic                          busy;
  logic [$clog2(N_SRC+1)-1:0]    active_id;
  logic [1:0]                    dbg_state;

  // Controller side
  modport slave (
    input  irq_in, irq_en, i_syscall, inmediate_syscall, s_finished,
    input  tbl_we, tbl_addr, tbl_data,
    output dir_out, s_interruption, busy, active_id, dbg_state
  );

  // Core / stimulus side
  modport master (
    output irq_in, irq_en, i_syscall, inmediate_syscall, s_finished,
    output tbl_we, tbl_addr, tbl_data,
    input  dir_out, s_interruption, busy, active_id, dbg_state
  );
endinterface

// File: rtl/interrupt_controller.sv
// Parametrised interrupt controller: edge-latched hardware sources plus one
// syscall slot, fixed-priority arbitration with enable mask, one-cycle
// dispatch pulse and a writable syscall vector table.
module interrupt_controller #(
  parameter int                N_SRC    = 4,
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] VEC_BASE = 10'h3FA,
  parameter int                SC_DEPTH = 4,   // power of two, at least 2
  parameter int                IMM_W    = 8
) (
  input logic                    clk,
  input logic                    reset,
  interrupt_controller_if.slave  bus
);
  localparam int SEL_W = $clog2(SC_DEPTH);
  localparam int ID_W  = $clog2(N_SRC + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SIGNAL = 2'd1, SERVICE = 2'd2} state_t;

  state_t             state_q;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   irq_prev_q;
  logic               sc_pending_q, sc_pending_d;
  logic [SEL_W-1:0]   sc_idx_q;
  logic [ADDR_W-1:0]  sc_tbl_q [SC_DEPTH];
  logic [ADDR_W-1:0]  dir_out_q;
  logic               s_int_q;
  logic               busy_q;
  logic [ID_W-1:0]    active_id_q;

  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   eligible;
  logic [N_SRC-1:0]   win_mask;
  logic [ID_W-1:0]    win_id;
  logic               win_valid;
  logic               grant_hw;
  logic               grant_sc;
  logic [ADDR_W-1:0]  hw_vec;

  // Only the low SEL_W immediate bits select a table entry.
  logic unused_imm;
  assign unused_imm = ^bus.inmediate_syscall;

  assign rise     = bus.irq_in & ~irq_prev_q;
  assign eligible = pending_q & bus.irq_en;

  // Lowest eligible index wins; scan high to low so the last hit is the lowest.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    win_mask  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_valid   = 1'b1;
        win_id      = ID_W'(i);
        win_mask    = '0;
        win_mask[i] = 1'b1;
      end
    end
  end

  assign grant_hw = (state_q == IDLE) && win_valid;
  assign grant_sc = (state_q == IDLE) && !win_valid && sc_pending_q;
  assign hw_vec   = VEC_BASE + ADDR_W'(win_id);

  // A new edge/syscall in the grant cycle wins over the clear.
  assign pending_d    = (pending_q & ~(grant_hw ? win_mask : '0)) | rise;
  assign sc_pending_d = (sc_pending_q & ~grant_sc) | bus.i_syscall;

  // Edge detection, pending latches and the single syscall slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q    <= '0;
      irq_prev_q   <= '0;
      sc_pending_q <= 1'b0;
      sc_idx_q     <= '0;
    end else begin
      pending_q    <= pending_d;
      irq_prev_q   <= bus.irq_in;
      sc_pending_q <= sc_pending_d;
      if (bus.i_syscall) sc_idx_q <= bus.inmediate_syscall[SEL_W-1:0];
    end
  end

  // Syscall vector table; a read in the grant cycle sees the pre-write value.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SC_DEPTH; i++) sc_tbl_q[i] <= '0;
    end else if (bus.tbl_we) begin
      sc_tbl_q[bus.tbl_addr] <= bus.tbl_data;
    end
  end

  // Dispatch FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dir_out_q   <= '0;
      s_int_q     <= 1'b0;
      busy_q      <= 1'b0;
      active_id_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          s_int_q <= 1'b0;
          busy_q  <= 1'b0;
          if (grant_hw) begin
            dir_out_q   <= hw_vec;
            active_id_q <= win_id;
            s_int_q     <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= SIGNAL;
          end else if (grant_sc) begin
            dir_out_q   <= sc_tbl_q[sc_idx_q];
            active_id_q <= ID_W'(N_SRC);
            s_int_q     <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= SIGNAL;
          end
        end
        SIGNAL: begin
          s_int_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= SERVICE;
        end
        SERVICE: begin
          if (bus.s_finished) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          s_int_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.dir_out        = dir_out_q;
  assign bus.s_interruption = s_int_q;
  assign bus.busy           = busy_q;
  assign bus.active_id      = active_id_q;
  assign bus.dbg_state      = state_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: timing checks in the main flow,
// plus a dispatch scoreboard that pops one expected {active_id, dir_out}
// per s_interruption pulse.
module tb_interrupt_controller;
  localparam int N_SRC = 4;
  localparam int ADDR_W = 10;
  localparam int SC_DEPTH = 4;
  localparam int IMM_W = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  logic [31:0] exp_q[$];

  interrupt_controller_if #(.N_SRC(N_SRC), .ADDR_W(ADDR_W), .SC_DEPTH(SC_DEPTH), .IMM_W(IMM_W)) bus_if ();

  interrupt_controller #(
    .N_SRC(N_SRC), .ADDR_W(ADDR_W), .VEC_BASE(10'h3FA), .SC_DEPTH(SC_DEPTH), .IMM_W(IMM_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] disp(input int id, input int addr);
    return 32'(id * 1024 + addr);
  endfunction

  // scoreboard: every dispatch pulse must match the next expected entry
  always @(negedge clk) begin
    if (!reset && bus_if.s_interruption) begin
      check("dispatch_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check("dispatch", {19'd0, bus_if.active_id, bus_if.dir_out}, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic finish_service();
    bus_if.s_finished = 1'b1;
    tick();
    bus_if.s_finished = 1'b0;
  endtask

  task automatic quiet_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, 32'(bus_if.s_interruption), 32'd0);
    end
  endtask

  task automatic expect_pulse(input string tag, input int id, input int addr);
    check({tag, "_pulse"}, 32'(bus_if.s_interruption), 32'd1);
    check({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
    check({tag, "_dir"}, 32'(bus_if.dir_out), 32'(addr));
    check({tag, "_id"}, 32'(bus_if.active_id), 32'(id));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    bus_if.irq_in = '0;
    bus_if.irq_en = 4'b1111;
    bus_if.i_syscall = 1'b0;
    bus_if.inmediate_syscall = '0;
    bus_if.s_finished = 1'b0;
    bus_if.tbl_we = 1'b0;
    bus_if.tbl_addr = '0;
    bus_if.tbl_data = '0;
    ticks(2);
    check("rst_dir", 32'(bus_if.dir_out), 32'd0);
    check("rst_pulse", 32'(bus_if.s_interruption), 32'd0);
    check("rst_busy", 32'(bus_if.busy), 32'd0);
    check("rst_id", 32'(bus_if.active_id), 32'd0);
    check("rst_state", 32'(bus_if.dbg_state), 32'd0);
    reset = 1'b0;
    tick();

    // single source 2 pulse: pulse two cycles after the edge cycle
    exp_q.push_back(disp(2, 10'h3FC));
    bus_if.irq_in = 4'b0100;
    tick();
    check("t1_no_early_pulse", 32'(bus_if.s_interruption), 32'd0);
    bus_if.irq_in = 4'b0000;
    tick();
    expect_pulse("t1", 2, 10'h3FC);
    check("t1_state_signal", 32'(bus_if.dbg_state), 32'd1);
    tick();
    check("t1_pulse_one_cycle", 32'(bus_if.s_interruption), 32'd0);
    ticks(3);
    check("t1_busy_held", 32'(bus_if.busy), 32'd1);
    check("t1_dir_held", 32'(bus_if.dir_out), 32'h3FC);
    finish_service();
    check("t1_busy_drop", 32'(bus_if.busy), 32'd0);
    quiet_cycles("t1_quiet", 2);

    // sources 3 and 0 together: 0 first, 3 exactly three cycles later
    exp_q.push_back(disp(0, 10'h3FA));
    exp_q.push_back(disp(3, 10'h3FD));
    bus_if.irq_in = 4'b1001;
    tick();
    bus_if.irq_in = 4'b0000;
    tick();
    expect_pulse("t2a", 0, 10'h3FA);
    bus_if.s_finished = 1'b1;   // ignored in SIGNAL
    tick();
    check("t2_signal_ignores_fin", 32'(bus_if.busy), 32'd1);
    tick();                     // SERVICE sees s_finished
    bus_if.s_finished = 1'b0;
    check("t2_idle_gap", 32'(bus_if.s_interruption), 32'd0);
    tick();
    expect_pulse("t2b", 3, 10'h3FD);
    tick();
    finish_service();

    // syscall via table entry 1 (immediate 8'h05 -> index 1), with source 1 edge
    bus_if.tbl_we = 1'b1; bus_if.tbl_addr = 2'd1; bus_if.tbl_data = 10'h120;
    tick();
    bus_if.tbl_we = 1'b0;
    exp_q.push_back(disp(1, 10'h3FB));
    exp_q.push_back(disp(4, 10'h120));
    bus_if.irq_in = 4'b0010;
    bus_if.i_syscall = 1'b1; bus_if.inmediate_syscall = 8'h05;
    tick();
    bus_if.irq_in = 4'b0000;
    bus_if.i_syscall = 1'b0; bus_if.inmediate_syscall = 8'h00;
    tick();
    expect_pulse("t3_src1", 1, 10'h3FB);
    tick();
    finish_service();
    tick();
    expect_pulse("t3_sc", 4, 10'h120);
    tick();
    finish_service();

    // read-before-write on the syscall grant
    bus_if.tbl_we = 1'b1; bus_if.tbl_addr = 2'd2; bus_if.tbl_data = 10'h055;
    tick();
    bus_if.tbl_we = 1'b0;
    exp_q.push_back(disp(4, 10'h055));
    bus_if.i_syscall = 1'b1; bus_if.inmediate_syscall = 8'h02;
    tick();
    bus_if.i_syscall = 1'b0;
    bus_if.tbl_we = 1'b1; bus_if.tbl_addr = 2'd2; bus_if.tbl_data = 10'h0AA;
    tick();
    bus_if.tbl_we = 1'b0;
    expect_pulse("t3_rbw", 4, 10'h055);
    tick();
    finish_service();
    exp_q.push_back(disp(4, 10'h0AA));
    bus_if.i_syscall = 1'b1; bus_if.inmediate_syscall = 8'hFE;  // upper bits ignored
    tick();
    bus_if.i_syscall = 1'b0;
    tick();
    expect_pulse("t3_newval", 4, 10'h0AA);
    tick();
    finish_service();

    // masked source 1 stays pending, dispatched once enabled
    bus_if.irq_en = 4'b1101;
    bus_if.irq_in = 4'b0010;
    tick();
    bus_if.irq_in = 4'b0000;
    quiet_cycles("t4_masked", 4);
    exp_q.push_back(disp(1, 10'h3FB));
    bus_if.irq_en = 4'b1111;
    tick();
    expect_pulse("t4_unmask", 1, 10'h3FB);
    tick();
    finish_service();
    quiet_cycles("t4_once", 2);

    // source 0 held high: one dispatch; a fresh edge in SERVICE gives another
    exp_q.push_back(disp(0, 10'h3FA));
    bus_if.irq_in = 4'b0001;
    ticks(2);
    expect_pulse("t5a", 0, 10'h3FA);
    quiet_cycles("t5_level", 4);
    bus_if.irq_in = 4'b0000;
    tick();
    bus_if.irq_in = 4'b0001;
    tick();
    exp_q.push_back(disp(0, 10'h3FA));
    finish_service();
    tick();
    expect_pulse("t5b", 0, 10'h3FA);
    tick();
    finish_service();
    quiet_cycles("t5_no_third", 3);
    bus_if.irq_in = 4'b0000;
    tick();

    // edge coinciding with its own grant-clear keeps the bit pending
    bus_if.irq_en = 4'b1011;
    bus_if.irq_in = 4'b0100;
    tick();
    bus_if.irq_in = 4'b0000;
    tick();
    exp_q.push_back(disp(2, 10'h3FC));
    exp_q.push_back(disp(2, 10'h3FC));
    bus_if.irq_en = 4'b1111;
    bus_if.irq_in = 4'b0100;
    tick();
    bus_if.irq_in = 4'b0000;
    expect_pulse("t6a", 2, 10'h3FC);
    tick();
    finish_service();
    tick();
    expect_pulse("t6b", 2, 10'h3FC);
    tick();
    finish_service();

    // reset during SERVICE with source 3 pending
    exp_q.push_back(disp(0, 10'h3FA));
    bus_if.irq_in = 4'b1001;
    tick();
    bus_if.irq_in = 4'b0000;
    tick();
    expect_pulse("t7", 0, 10'h3FA);
    tick();
    check("t7_in_service", 32'(bus_if.dbg_state), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t7_rst_busy", 32'(bus_if.busy), 32'd0);
    check("t7_rst_pulse", 32'(bus_if.s_interruption), 32'd0);
    check("t7_rst_dir", 32'(bus_if.dir_out), 32'd0);
    check("t7_rst_id", 32'(bus_if.active_id), 32'd0);
    quiet_cycles("t7_lost", 5);
    check("t7_idle_busy", 32'(bus_if.busy), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Parametrised successor to the processor's fixed four-source interrupt module.
- Latches N_SRC hardware interrupt sources plus one syscall request, arbitrates them by fixed priority and applies a per-source enable mask.
- Signals the core with a one-cycle s_interruption pulse and a registered handler address on dir_out, then holds off further dispatch until the core reports s_finished.
- Syscall handler addresses come from a writable vector table indexed by the syscall immediate.

Parameters:
- N_SRC, 4: number of hardware interrupt sources; index 0 has the highest priority.
- ADDR_W, 10: width of handler addresses.
- VEC_BASE, 10'h3FA: handler address of source 0; source i vectors to VEC_BASE+i, modulo 2^ADDR_W.
- SC_DEPTH, 4: syscall vector table entries; must be a power of two.
- IMM_W, 8: syscall immediate width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  N_SRC  hardware interrupt request lines; rising-edge sensitive.
- irq_en  in  N_SRC  per-source enable; 1 = source may be dispatched.
- i_syscall  in  1  syscall request, sampled as a single-cycle pulse.
- inmediate_syscall  in  IMM_W  syscall immediate, valid while i_syscall=1.
- s_finished  in  1  core has returned from the handler.
- tbl_we  in  1  syscall table write strobe.
- tbl_addr  in  log2(SC_DEPTH)  syscall table write index.
- tbl_data  in  ADDR_W  syscall table write data.
- dir_out  out  ADDR_W  handler address.
- s_interruption  out  1  dispatch pulse.
- busy  out  1  a handler is in service.
- active_id  out  log2(N_SRC+1)  source in service; N_SRC denotes the syscall.

Behaviour:
- Reset:
  - pending=0, sc_pending=0, edge register=0, syscall table all 0, state=IDLE.
  - dir_out=0, s_interruption=0, busy=0, active_id=0.
- Edge detect:
  - pending[i] is set when irq_in[i]=1 and the previous-cycle sample is 0. Level-high alone never re-sets it.
  - Pending bits latch regardless of irq_en. A masked pending bit stays pending and is dispatched once enabled.
- Syscall capture:
  - i_syscall=1 sets sc_pending and captures inmediate_syscall[log2(SC_DEPTH)-1:0].
  - A second i_syscall while sc_pending=1 overwrites the captured index; there is only one slot.
- Priority: eligible = pending & irq_en. Dispatch order is the lowest set index first; the syscall ranks below all hardware sources.
- FSM IDLE:
  - If eligible != 0 or sc_pending=1, go to SIGNAL on the next edge.
  - On that same edge: load dir_out and active_id, and clear the winning pending bit.
  - Syscall vector: dir_out = table[captured index].
- FSM SIGNAL:
  - s_interruption=1 and busy=1 for exactly this one cycle.
  - Go to SERVICE unconditionally. s_finished is ignored in SIGNAL.
- FSM SERVICE:
  - busy=1; dir_out and active_id are held stable.
  - On s_finished=1, go to IDLE; busy falls on the next cycle.
- Back-to-back: a request still eligible in IDLE is granted on the first IDLE cycle. Minimum spacing between s_interruption pulses is 3 cycles. There is no nesting and no preemption.
- Simultaneous set/clear: if a source's rising edge coincides with its own grant-clear, set wins and the bit stays pending.
- Table access:
  - Writes take effect at the clock edge.
  - A write in the same cycle as a syscall grant to the same entry returns the old value (read-before-write).
- Latency: rising edge of irq_in in cycle n, with the controller idle, gives s_interruption=1 in cycle n+2.
- Reset mid-operation: returns every register to its reset value in one cycle; all pending requests are lost.
- Arithmetic: VEC_BASE+i wraps modulo 2^ADDR_W. Immediate bits above log2(SC_DEPTH) are ignored.

Test Plan:
- Reset, then single irq_in[2] pulse, irq_en=4'b1111:
  - s_interruption in cycle 2 after the edge; dir_out=10'h3FC; active_id=2; busy stays 1 until s_finished.
- irq_in[3] and irq_in[0] rise together:
  - source 0 dispatched (dir_out=10'h3FA); after s_finished, source 3 dispatched (10'h3FD) three cycles after the first pulse.
- Write table[1]=10'h120, then i_syscall with inmediate_syscall=8'h05:
  - dir_out=10'h120, active_id=4.
  - With a simultaneous irq_in[1] edge, source 1 is served first and the syscall after it.
- irq_en[1]=0, irq_in[1] pulses:
  - no dispatch; after irq_en[1] is raised, dispatch occurs within 2 cycles with dir_out=10'h3FB.
- irq_in[0] held high across its own service:
  - exactly one dispatch.
  - A new 0->1 edge during SERVICE produces a second dispatch after s_finished.
- Assert reset during SERVICE with pending[3]=1:
  - busy=0, s_interruption=0, dir_out=0 next cycle; no dispatch afterwards without a new edge.
